// File: rtl/pixel_capture.sv
// Camera byte-stream capture: extracts luma from YUV422 and writes it into a
// row-major grayscale frame buffer, with frame sync handling and overflow flag.
module pixel_capture #(
   parameter int unsigned H_RES         = 640,
   parameter int unsigned V_RES         = 480,
   parameter int unsigned CLAMP_MARKERS = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  byte_in,
   output logic        we,
   output logic [19:0] write_addr,
   output logic [7:0]  pixel_out,
   output logic        frame_done,
   output logic [7:0]  frame_count,
   output logic        overflow
);

   localparam int unsigned AW    = 20;
   localparam int unsigned COL_W = $clog2(H_RES + 1);
   localparam int unsigned ROW_W = $clog2(V_RES + 1);

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      WAIT_LINE  = 2'd1,
      ACTIVE     = 2'd2
   } state_e;

   state_e           state_q;
   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q;
   logic [AW-1:0]    base_q;
   logic             phase_q;
   logic             vs_q;
   logic             vs_seen_q;

   logic             vs_fall;
   logic             vs_rise;
   logic             href_ok;
   logic             luma;
   logic             in_range;
   logic [7:0]       pix_d;
   logic [AW-1:0]    addr_d;
   logic [COL_W-1:0] col_d;

   // vs_seen_q keeps the reset value of the history from faking an edge
   always_comb begin
      vs_fall  = vs_seen_q & vs_q & ~vsync;
      vs_rise  = vs_seen_q & ~vs_q & vsync;
      href_ok  = href & ~vsync;
      luma     = href_ok & ((state_q == WAIT_LINE) | ((state_q == ACTIVE) & ~phase_q));
      in_range = (col_q < COL_W'(H_RES)) && (row_q < ROW_W'(V_RES));
      pix_d    = ((CLAMP_MARKERS != 0) && (byte_in > 8'd253)) ? 8'd253 : byte_in;
      addr_d   = base_q + AW'(col_q);
      col_d    = (col_q < COL_W'(H_RES)) ? col_q + COL_W'(1) : col_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT_FRAME;
         col_q       <= '0;
         row_q       <= '0;
         base_q      <= '0;
         phase_q     <= 1'b0;
         vs_q        <= 1'b1;
         vs_seen_q   <= 1'b0;
         we          <= 1'b0;
         write_addr  <= '0;
         pixel_out   <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         overflow    <= 1'b0;
      end else begin
         we         <= 1'b0;
         frame_done <= 1'b0;
         vs_q       <= vsync;
         vs_seen_q  <= 1'b1;

         if (luma) begin
            if (in_range) begin
               we         <= 1'b1;
               write_addr <= addr_d;
               pixel_out  <= pix_d;
            end else begin
               overflow <= 1'b1;
            end
            col_q <= col_d;
         end

         case (state_q)
            WAIT_FRAME: begin
               if (vs_fall) begin
                  state_q  <= WAIT_LINE;
                  row_q    <= '0;
                  col_q    <= '0;
                  base_q   <= '0;
                  phase_q  <= 1'b0;
                  overflow <= 1'b0;
               end
            end
            WAIT_LINE: begin
               if (vs_rise) begin
                  state_q     <= WAIT_FRAME;
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 8'd1;
               end else if (href_ok) begin
                  state_q <= ACTIVE;
                  phase_q <= 1'b1;
               end
            end
            ACTIVE: begin
               if (vs_rise) begin
                  state_q     <= WAIT_FRAME;
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 8'd1;
               end else if (href_ok) begin
                  phase_q <= ~phase_q;
               end else if (!href) begin
                  // line base stops advancing past the last row so it never wraps
                  state_q <= WAIT_LINE;
                  col_q   <= '0;
                  phase_q <= 1'b0;
                  if (row_q < ROW_W'(V_RES)) begin
                     row_q  <= row_q + ROW_W'(1);
                     base_q <= base_q + AW'(H_RES);
                  end
               end
            end
            default: state_q <= WAIT_FRAME;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_capture.sv
// Self-checking bench for pixel_capture: scoreboard of expected frame-memory
// writes built from line/pixel descriptions, plus corner-case sequences.
module tb_pixel_capture;

   localparam int unsigned H = 16;
   localparam int unsigned V = 6;
   localparam int unsigned N = H * V;

   logic        clk = 1'b0;
   logic        reset;
   logic        vsync;
   logic        href;
   logic [7:0]  byte_in;
   logic        we, we_n;
   logic [19:0] addr, addr_n;
   logic [7:0]  pix, pix_n;
   logic        fd, fd_n;
   logic [7:0]  fc, fc_n;
   logic        ovf, ovf_n;

   always #5 clk = ~clk;

   pixel_capture #(.H_RES(H), .V_RES(V), .CLAMP_MARKERS(1)) dut (
      .clk(clk), .reset(reset), .vsync(vsync), .href(href), .byte_in(byte_in),
      .we(we), .write_addr(addr), .pixel_out(pix), .frame_done(fd),
      .frame_count(fc), .overflow(ovf));

   pixel_capture #(.H_RES(H), .V_RES(V), .CLAMP_MARKERS(0)) dut_nc (
      .clk(clk), .reset(reset), .vsync(vsync), .href(href), .byte_in(byte_in),
      .we(we_n), .write_addr(addr_n), .pixel_out(pix_n), .frame_done(fd_n),
      .frame_count(fc_n), .overflow(ovf_n));

   typedef struct {
      int unsigned addr;
      int unsigned pix;
      int unsigned pixn;
   } wr_t;

   typedef struct {
      logic [7:0] y;
      logic [7:0] exp_c;
      logic [7:0] exp_n;
   } vec_t;

   wr_t         act_q[$];
   wr_t         exp_q[$];
   logic [7:0]  ybuf[$];
   logic [7:0]  cbuf[$];
   vec_t        tbl[7];

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned fd_seen = 0;
   int unsigned fd_long = 0;
   logic        fd_prev = 1'b0;
   int unsigned exp_fd = 0;
   logic [7:0]  exp_fc = 8'd0;
   logic        exp_ovf = 1'b0;
   int unsigned ln = 0;

   task automatic chk(input bit ok, input string name, input int unsigned a, input int unsigned r);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, a, r);
      end
   endtask

   // Write monitor: collects every frame-memory write and frame_done pulse
   always @(negedge clk) begin
      if (reset) begin
         fd_prev <= 1'b0;
      end else begin
         if (we) begin
            chk(32'(addr) < N, "addr_range", 32'(addr), N - 1);
            act_q.push_back('{32'(addr), 32'(pix), 32'(pix_n)});
         end
         if (fd) begin
            fd_seen <= fd_seen + 1;
            if (fd_prev) fd_long <= fd_long + 1;
         end
         fd_prev <= fd;
      end
   end

   task automatic tick(input int unsigned n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] min253(input logic [7:0] y);
      return (y > 8'd253) ? 8'd253 : y;
   endfunction

   // One camera line of n pixels; the model records which luma should land where
   task automatic drive_line(input int unsigned n);
      href = 1'b1;
      for (int unsigned k = 0; k < n; k++) begin
         logic [7:0] y;
         logic [7:0] c;
         y = (ybuf.size() != 0) ? ybuf.pop_front() : 8'($urandom);
         c = (cbuf.size() != 0) ? cbuf.pop_front() : 8'($urandom);
         if (k < H && ln < V) exp_q.push_back('{ln * H + k, 32'(min253(y)), 32'(y)});
         else exp_ovf = 1'b1;
         byte_in = y;
         tick();
         byte_in = c;
         tick();
      end
      href = 1'b0;
      byte_in = 8'($urandom);
      tick(1 + $urandom_range(2));
      ln++;
   endtask

   // href activity that must never produce a write
   task automatic junk_line(input int unsigned n);
      href = 1'b1;
      repeat (2 * n) begin
         byte_in = 8'($urandom);
         tick();
      end
      href = 1'b0;
      tick();
   endtask

   task automatic frame_start();
      vsync = 1'b1;
      tick(2);
      vsync = 1'b0;
      tick(2);
      ln = 0;
      exp_ovf = 1'b0;
   endtask

   task automatic frame_end();
      vsync = 1'b1;
      tick(3);
      exp_fc = exp_fc + 8'd1;
      exp_fd++;
   endtask

   task automatic check_writes(input string name);
      int unsigned m;
      chk(act_q.size() == exp_q.size(), {name, "_nwrites"}, act_q.size(), exp_q.size());
      m = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int unsigned i = 0; i < m; i++) begin
         chk(act_q[i].addr == exp_q[i].addr, {name, "_addr"}, act_q[i].addr, exp_q[i].addr);
         chk(act_q[i].pix == exp_q[i].pix, {name, "_pix"}, act_q[i].pix, exp_q[i].pix);
         chk(act_q[i].pixn == exp_q[i].pixn, {name, "_pix_noclamp"}, act_q[i].pixn, exp_q[i].pixn);
      end
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic check_status(input string name);
      chk(fd_seen == exp_fd, {name, "_frame_done_pulses"}, fd_seen, exp_fd);
      chk(fd_long == 0, {name, "_frame_done_width"}, fd_long, 0);
      chk(fc == exp_fc, {name, "_frame_count"}, 32'(fc), 32'(exp_fc));
      chk(ovf == exp_ovf, {name, "_overflow"}, 32'(ovf), 32'(exp_ovf));
   endtask

   initial begin
      tbl[0] = '{8'd0,   8'd0,   8'd0};
      tbl[1] = '{8'd10,  8'd10,  8'd10};
      tbl[2] = '{8'd128, 8'd128, 8'd128};
      tbl[3] = '{8'd252, 8'd252, 8'd252};
      tbl[4] = '{8'd253, 8'd253, 8'd253};
      tbl[5] = '{8'd254, 8'd253, 8'd254};
      tbl[6] = '{8'd255, 8'd253, 8'd255};

      reset = 1'b1; vsync = 1'b1; href = 1'b0; byte_in = 8'd0;
      tick(3);
      chk(we == 1'b0, "rst_we", 32'(we), 0);
      chk(addr == 20'd0, "rst_addr", 32'(addr), 0);
      chk(pix == 8'd0, "rst_pix", 32'(pix), 0);
      chk(fd == 1'b0, "rst_frame_done", 32'(fd), 0);
      chk(fc == 8'd0, "rst_frame_count", 32'(fc), 0);
      chk(ovf == 1'b0, "rst_overflow", 32'(ovf), 0);
      reset = 1'b0;
      tick(2);

      // Basic Y/U/Y/V line, then a line of clamp-boundary values
      frame_start();
      ybuf = '{8'd10, 8'd20};
      cbuf = '{8'd80, 8'd90};
      drive_line(2);
      for (int i = 0; i < 7; i++) ybuf.push_back(tbl[i].y);
      drive_line(7);
      chk(act_q.size() == 9, "tbl_nwrites", act_q.size(), 9);
      if (act_q.size() == 9) begin
         for (int unsigned i = 0; i < 7; i++) begin
            chk(act_q[2 + i].addr == H + i, "tbl_addr", act_q[2 + i].addr, H + i);
            chk(act_q[2 + i].pix == 32'(tbl[i].exp_c), "tbl_clamp", act_q[2 + i].pix, 32'(tbl[i].exp_c));
            chk(act_q[2 + i].pixn == 32'(tbl[i].exp_n), "tbl_noclamp", act_q[2 + i].pixn, 32'(tbl[i].exp_n));
         end
      end
      frame_end();
      check_writes("basic");
      check_status("basic");

      // Full frame
      frame_start();
      for (int unsigned r = 0; r < V; r++) drive_line(H);
      frame_end();
      chk(act_q.size() != 0 && act_q[act_q.size() - 1].addr == N - 1, "full_last_addr",
          (act_q.size() != 0) ? act_q[act_q.size() - 1].addr : 0, N - 1);
      check_writes("full");
      check_status("full");

      // Short line, full line, long line, then rows beyond V
      frame_start();
      drive_line(5);
      drive_line(H);
      chk(act_q.size() > 5 && act_q[5].addr == H, "short_next_base",
          (act_q.size() > 5) ? act_q[5].addr : 0, H);
      drive_line(H + 5);
      for (int unsigned r = 3; r < V + 2; r++) drive_line(3);
      frame_end();
      check_writes("ovf");
      check_status("ovf");
      frame_start();
      chk(ovf == 1'b0, "ovf_cleared", 32'(ovf), 0);
      drive_line(4);
      frame_end();
      check_writes("after_ovf");
      check_status("after_ovf");

      // Reset mid-line aborts capture until a fresh vsync falling edge
      frame_start();
      drive_line(H);
      drive_line(H);
      drive_line(H);
      drive_line(H);
      drive_line(H);
      href = 1'b1;
      for (int unsigned k = 0; k < 6; k++) begin
         exp_q.push_back('{ln * H + k, 32'(8'd40 + 8'(k)), 32'(8'd40 + 8'(k))});
         byte_in = 8'd40 + 8'(k);
         tick();
         byte_in = 8'd99;
         tick();
      end
      vsync = 1'b0;
      reset = 1'b1;
      #1;
      chk(we == 1'b0, "midrst_we", 32'(we), 0);
      chk(fc == 8'd0, "midrst_frame_count", 32'(fc), 0);
      chk(addr == 20'd0, "midrst_addr", 32'(addr), 0);
      check_writes("pre_reset");
      tick(2);
      href = 1'b0;
      reset = 1'b0;
      exp_fc = 8'd0;
      exp_ovf = 1'b0;
      tick(2);
      junk_line(8);
      junk_line(8);
      check_writes("post_reset_idle");
      frame_start();
      chk(fd_seen == exp_fd, "wait_frame_rise_no_pulse", fd_seen, exp_fd);
      drive_line(4);
      chk(fc == 8'd0, "restart_frame_count", 32'(fc), 0);
      frame_end();
      check_writes("restart");
      check_status("restart");

      // vsync rising while href is high mid-line
      frame_start();
      drive_line(H);
      href = 1'b1;
      for (int unsigned k = 0; k < 8; k++) begin
         if (k == 4) vsync = 1'b1;
         if (k < 4) exp_q.push_back('{ln * H + k, 32'(8'd200), 32'(8'd200)});
         byte_in = 8'd200;
         tick();
         byte_in = 8'd7;
         tick();
      end
      href = 1'b0;
      tick(2);
      exp_fc = exp_fc + 8'd1;
      exp_fd++;
      check_writes("vs_midline");
      check_status("vs_midline");

      // Randomized frames, with href noise during vertical blanking
      repeat (5) begin
         int unsigned nl;
         frame_start();
         nl = $urandom_range(V + 1, 1);
         for (int unsigned r = 0; r < nl; r++) drive_line($urandom_range(H + 3, 1));
         frame_end();
         junk_line(5);
         check_writes("rand");
         check_status("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pixel_capture.md
PIXEL_CAPTURE -- requirements
Module: pixel_capture

Interface
REQ-001 Parameter H_RES, default 640, pixels per line written to frame memory.
REQ-002 Parameter V_RES, default 480, lines per frame written to frame memory.
REQ-003 Parameter CLAMP_MARKERS, default 1; when 1, captured luma is clamped to max 253, reserving 254/255 as display marker colours.
REQ-004 clk  input  1  camera pixel clock (PCLK); all logic on rising edge; sole clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 vsync  input  1  camera frame sync; high = vertical blanking.
REQ-007 href  input  1  camera line valid; high = byte_in carries pixel data.
REQ-008 byte_in  input  8  camera data bus, YUV422 order Y0 U0 Y1 V0 ...
REQ-009 we  output  1  one-cycle write strobe to frame memory.
REQ-010 write_addr  output  20  frame memory address, row*H_RES + col.
REQ-011 pixel_out  output  8  grayscale pixel, valid when we=1.
REQ-012 frame_done  output  1  one-cycle pulse when a frame ends.
REQ-013 frame_count  output  8  completed frames, wraps 255->0.
REQ-014 overflow  output  1  sticky: data arrived beyond H_RES columns or V_RES rows in current frame.

Function
REQ-015 FSM states SHALL be WAIT_FRAME, WAIT_LINE, ACTIVE.
REQ-016 WAIT_FRAME: ignore href/byte_in; on vsync falling edge (1 then 0 on consecutive samples) -> WAIT_LINE, row=0, col=0, overflow cleared.
REQ-017 WAIT_LINE: on href=1 -> ACTIVE, byte phase=0, that byte treated as phase 0 (Y).
REQ-018 ACTIVE: each href=1 cycle toggles byte phase; phase-0 bytes are luma, phase-1 bytes (U/V) are discarded.
REQ-019 Luma byte sampled at edge N SHALL produce we=1, pixel_out, write_addr at edge N+1 (latency 1); we=0 all other cycles.
REQ-020 pixel_out = min(Y,253) when CLAMP_MARKERS=1, else Y unchanged.
REQ-021 write_addr = row*H_RES + col, computed without multiplier (running line-base register incremented by H_RES per line); col increments after each luma write.
REQ-022 Luma with col >= H_RES or row >= V_RES: no write, overflow set to 1, col still saturates at H_RES.
REQ-023 href falling edge in ACTIVE -> WAIT_LINE, row+1, col=0, line base += H_RES; short lines (col < H_RES) leave unwritten tail, next line starts at its aligned base.
REQ-024 vsync rising edge in WAIT_LINE or ACTIVE -> WAIT_FRAME, frame_done=1 for one cycle, frame_count+1; a luma write pending from the previous edge still completes.
REQ-025 href=1 while vsync=1 SHALL be ignored in every state.
REQ-026 write_addr SHALL never exceed H_RES*V_RES-1 while we=1.
REQ-027 vsync rising edge while in WAIT_FRAME: no frame_done pulse, no count change.

Reset
REQ-028 reset=1 SHALL asynchronously force state WAIT_FRAME, we=0, write_addr=0, pixel_out=0, frame_done=0, frame_count=0, overflow=0, row/col/line base/phase=0, vsync edge history=1.
REQ-029 Reset asserted mid-line SHALL abort it; after release, no write occurs before a new vsync falling edge.

Verification
REQ-030 Reset, vsync 1->0, href=1 with bytes 10,80,20,90 -> we pulses with (addr 0, pixel 10) then (addr 1, pixel 20); U/V never written.
REQ-031 Full 640x480 frame, then vsync 0->1 -> 307200 writes, last addr 307199, frame_done one cycle, frame_count=1, overflow=0.
REQ-032 Luma bytes 253,254,255 with CLAMP_MARKERS=1 -> pixel_out 253,253,253; with CLAMP_MARKERS=0 -> 253,254,255.
REQ-033 Line 0 of 100 pixels, line 1 full -> line 1 first write addr 640; line of 700 pixels -> writes stop at col 639, overflow=1 until next frame start.
REQ-034 Reset asserted at col 300 of row 5, released, href pulses without vsync edge -> no we; after vsync 1->0 capture restarts at addr 0, frame_count=0.
REQ-035 Vsync rising while href high mid-line -> immediate WAIT_FRAME, frame_done pulse, subsequent href bytes produce no writes.
